// File: rtl/ucode_sequencer.sv
// ucode_sequencer
// Walks a microcode chain for one JVM bytecode at a time. The opcode itself is
// the first micro-address; each following address comes from a combinational
// next-address ROM. A chain ends when the ROM returns 0. It faults when the ROM
// returns all-ones, or when the chain grows past MAX_STEPS micro-ops.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   op_valid/op_ready     opcode handshake; op_code is the 8-bit JVM opcode
//   rom_addr/rom_data     next-address ROM lookup (combinational ROM)
//   uop_valid/uop_ready   micro-op handshake; uop_addr/uop_last describe it
//   busy                  high whenever the sequencer is not idle
//   err/err_code          sticky fault (01 invalid address, 10 step overflow)
//   err_clr               acknowledges a fault and returns to idle
//   insn_count            completed bytecodes, wraps modulo 2^16
module ucode_sequencer #(
  parameter int MAX_STEPS = 32,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_code,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] rom_data,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr,
  output logic [15:0]       insn_count
);

  // Step counter only has to reach MAX_STEPS-1; keep at least one bit.
  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EMIT  = 2'b01,
    ERROR = 2'b10
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [STEP_W-1:0] step_r;
  logic              op_ready_r;
  logic              uop_valid_r;
  logic              busy_r;
  logic              err_r;
  logic [1:0]        err_code_r;
  logic [15:0]       insn_count_r;

  logic [ADDR_W-1:0] op_addr_s;
  logic              rom_end_s;
  logic              rom_inv_s;
  logic              fire_s;

  // ROM response decode and handshake detection.
  always_comb begin
    op_addr_s = ADDR_W'({1'b0, op_code});
    rom_end_s = (rom_data == {ADDR_W{1'b0}});
    rom_inv_s = (rom_data == {ADDR_W{1'b1}});
    fire_s    = uop_valid_r && uop_ready;
  end

  // The ROM is addressed by the opcode while idle so that its entry is
  // ready to use once the opcode has been loaded into cur_r.
  always_comb begin
    if (state_r == EMIT) begin
      rom_addr = cur_r;
      uop_last = rom_end_s;
    end else begin
      rom_addr = op_addr_s;
      uop_last = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cur_r        <= {ADDR_W{1'b0}};
      step_r       <= {STEP_W{1'b0}};
      op_ready_r   <= 1'b1;
      uop_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 2'b00;
      insn_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            cur_r       <= op_addr_s;
            step_r      <= {STEP_W{1'b0}};
            state_r     <= EMIT;
            op_ready_r  <= 1'b0;
            uop_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        EMIT: begin
          if (fire_s) begin
            if (rom_end_s) begin
              state_r      <= IDLE;
              op_ready_r   <= 1'b1;
              uop_valid_r  <= 1'b0;
              busy_r       <= 1'b0;
              insn_count_r <= insn_count_r + 16'd1;
            end else if (rom_inv_s) begin
              state_r     <= ERROR;
              uop_valid_r <= 1'b0;
              err_r       <= 1'b1;
              err_code_r  <= 2'b01;
            end else if (step_r == STEP_LAST) begin
              state_r     <= ERROR;
              uop_valid_r <= 1'b0;
              err_r       <= 1'b1;
              err_code_r  <= 2'b10;
            end else begin
              cur_r  <= rom_data;
              step_r <= step_r + STEP_ONE;
            end
          end
        end
        ERROR: begin
          if (err_clr) begin
            state_r    <= IDLE;
            op_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
          end
        end
        default: begin
          state_r     <= IDLE;
          op_ready_r  <= 1'b1;
          uop_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready   = op_ready_r;
  assign uop_valid  = uop_valid_r;
  assign uop_addr   = cur_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign insn_count = insn_count_r;

endmodule

// File: tb/tb_ucode_sequencer.sv
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_code = 8'd0;
  logic [8:0]  rom_addr;
  logic [8:0]  rom_data;
  logic        uop_valid;
  logic        uop_ready = 1'b1;
  logic [8:0]  uop_addr;
  logic        uop_last;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr = 1'b0;
  logic [15:0] insn_count;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;  // 0 production, 1 invalid stub at 256, 2 self-loop

  ucode_sequencer #(.MAX_STEPS(32), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .rom_addr(rom_addr), .rom_data(rom_data),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_addr(uop_addr),
    .uop_last(uop_last), .busy(busy), .err(err), .err_code(err_code),
    .err_clr(err_clr), .insn_count(insn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_lookup(input logic [8:0] a, input int mode);
    if (mode == 2) return a;
    if (mode == 1 && a == 9'd256) return 9'h1FF;
    case (a)
      9'd89:  return 9'd256;
      9'd256: return 9'd257;
      9'd48:  return 9'd308;
      9'd308: return 9'd309;
      9'd309: return 9'd277;
      9'd277: return 9'd268;
      9'd11:  return 9'd268;
      9'd90:  return 9'd260;
      9'd260: return 9'd259;
      default: return 9'd0;
    endcase
  endfunction

  always_comb rom_data = rom_lookup(rom_addr, rom_mode);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; err_clr = 1'b0; uop_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one opcode; returns at the negedge (+1) where the first uop shows.
  task automatic issue(input logic [7:0] oc);
    @(negedge clk);
    op_valid = 1'b1; op_code = oc;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({uop_valid, op_ready, busy, err, err_code, uop_last} !== 7'b0100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b", {uop_valid, op_ready, busy, err, err_code, uop_last}, 7'b0100000);
    end
    checks++;
    if ({insn_count, uop_addr} !== 25'd0) begin
      errors++;
      $display("FAIL reset_regs got insn=%0d addr=%0d exp 0 0", insn_count, uop_addr);
    end
  endtask

  task automatic test_dup();
    logic [8:0] exp_a [0:2];
    exp_a = '{9'd89, 9'd256, 9'd257};
    do_reset(); rom_mode = 0;
    @(negedge clk);
    op_valid = 1'b1; op_code = 8'h59; #1;
    checks++;
    if ({op_ready, rom_addr} !== {1'b1, 9'd89}) begin
      errors++;
      $display("FAIL dup_idle got rdy=%b rom_addr=%0d exp 1 89", op_ready, rom_addr);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({uop_valid, uop_addr, uop_last} !== {1'b1, exp_a[i], (i == 2)}) begin
        errors++;
        $display("FAIL dup_uop%0d got v=%b a=%0d l=%b exp a=%0d", i, uop_valid, uop_addr, uop_last, exp_a[i]);
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({uop_valid, op_ready, insn_count} !== {1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL dup_done got v=%b rdy=%b cnt=%0d exp 0 1 1", uop_valid, op_ready, insn_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_a [0:4];
    exp_a = '{9'd48, 9'd308, 9'd309, 9'd277, 9'd268};
    do_reset(); rom_mode = 0;
    issue(8'h30);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({uop_valid, uop_addr, uop_last} !== {1'b1, exp_a[i], (i == 4)}) begin
        errors++;
        $display("FAIL b2b_first%0d got v=%b a=%0d l=%b exp a=%0d", i, uop_valid, uop_addr, uop_last, exp_a[i]);
      end
      @(negedge clk); #1;
    end
    // Bubble cycle: idle, offering the next opcode.
    op_valid = 1'b1; op_code = 8'h0B; #1;
    checks++;
    if ({uop_valid, op_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_bubble got v=%b rdy=%b exp 0 1", uop_valid, op_ready);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    checks++;
    if ({uop_valid, uop_addr, uop_last} !== {1'b1, 9'd11, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second0 got v=%b a=%0d l=%b exp 1 11 0", uop_valid, uop_addr, uop_last);
    end
    @(negedge clk); #1;
    checks++;
    if ({uop_valid, uop_addr, uop_last} !== {1'b1, 9'd268, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second1 got v=%b a=%0d l=%b exp 1 268 1", uop_valid, uop_addr, uop_last);
    end
    @(negedge clk); #1;
    checks++;
    if (insn_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 2", insn_count);
    end
  endtask

  task automatic test_single();
    do_reset(); rom_mode = 0;
    issue(8'h00);
    checks++;
    if ({uop_valid, uop_addr, uop_last, op_ready} !== {1'b1, 9'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_uop got v=%b a=%0d l=%b rdy=%b exp 1 0 1 0", uop_valid, uop_addr, uop_last, op_ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({uop_valid, op_ready, busy, insn_count} !== {1'b0, 1'b1, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL single_done got v=%b rdy=%b busy=%b cnt=%0d exp 0 1 0 1", uop_valid, op_ready, busy, insn_count);
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp_a [0:4];
    logic       rdy [0:4];
    exp_a = '{9'd90, 9'd260, 9'd260, 9'd260, 9'd259};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(); rom_mode = 0;
    issue(8'h5A);
    for (int i = 0; i < 5; i++) begin
      uop_ready = rdy[i]; #1;
      checks++;
      if ({uop_valid, uop_addr, uop_last} !== {1'b1, exp_a[i], (i == 4)}) begin
        errors++;
        $display("FAIL stall_c%0d got v=%b a=%0d l=%b exp a=%0d", i, uop_valid, uop_addr, uop_last, exp_a[i]);
      end
      @(negedge clk); #1;
    end
    uop_ready = 1'b1;
    checks++;
    if ({uop_valid, insn_count} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL stall_done got v=%b cnt=%0d exp 0 1", uop_valid, insn_count);
    end
  endtask

  task automatic test_err_invalid();
    do_reset(); rom_mode = 1;
    issue(8'h59);
    checks++;
    if ({uop_valid, uop_addr, uop_last} !== {1'b1, 9'd89, 1'b0}) begin
      errors++;
      $display("FAIL inv_uop0 got v=%b a=%0d l=%b exp 1 89 0", uop_valid, uop_addr, uop_last);
    end
    @(negedge clk); #1;
    checks++;
    if ({uop_valid, uop_addr, uop_last} !== {1'b1, 9'd256, 1'b0}) begin
      errors++;
      $display("FAIL inv_uop1 got v=%b a=%0d l=%b exp 1 256 0", uop_valid, uop_addr, uop_last);
    end
    @(negedge clk); @(negedge clk); #1;  // stays in error without err_clr
    checks++;
    if ({err, err_code, uop_valid, op_ready, busy} !== 6'b101001) begin
      errors++;
      $display("FAIL inv_err got %b exp %b", {err, err_code, uop_valid, op_ready, busy}, 6'b101001);
    end
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    checks++;
    if ({err, err_code, op_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL inv_clear got %b exp %b", {err, err_code, op_ready, busy}, 5'b00010);
    end
    rom_mode = 0;
  endtask

  task automatic test_err_overflow();
    int n = 0;
    do_reset(); rom_mode = 2;
    issue(8'h05);
    for (int i = 0; i < 40; i++) begin
      if (uop_valid) n++;
      if (err) break;
      @(negedge clk); #1;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL ovf_uops got %0d exp 32", n);
    end
    checks++;
    if ({err, err_code, insn_count} !== {1'b1, 2'b10, 16'd0}) begin
      errors++;
      $display("FAIL ovf_err got err=%b code=%b cnt=%0d exp 1 10 0", err, err_code, insn_count);
    end
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    checks++;
    if ({err, err_code, op_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_clear got %b exp %b", {err, err_code, op_ready}, 4'b0001);
    end
    rom_mode = 0;
  endtask

  task automatic test_reset_midchain();
    do_reset(); rom_mode = 0;
    issue(8'h30);
    @(negedge clk); #1;
    checks++;
    if ({uop_valid, uop_addr} !== {1'b1, 9'd308}) begin
      errors++;
      $display("FAIL mid_uop1 got v=%b a=%0d exp 1 308", uop_valid, uop_addr);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({uop_valid, op_ready, busy, insn_count, uop_addr} !== {3'b010, 16'd0, 9'd0}) begin
      errors++;
      $display("FAIL mid_reset got v=%b rdy=%b busy=%b cnt=%0d a=%0d exp 0 1 0 0 0", uop_valid, op_ready, busy, insn_count, uop_addr);
    end
  endtask

  initial begin
    test_reset();
    test_dup();
    test_back_to_back();
    test_single();
    test_stall();
    test_err_invalid();
    test_err_overflow();
    test_reset_midchain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter MAX_STEPS, default 32, SHALL set the maximum micro-ops emitted per bytecode before a step-overflow error.
REQ-002 Parameter ADDR_W, default 9, SHALL set the width of micro-address and ROM ports.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  bytecode opcode offered.
- op_ready  out  1  sequencer accepts an opcode.
- op_code  in  8  JVM opcode.
- rom_addr  out  ADDR_W  address to the combinational next-address ROM.
- rom_data  in  ADDR_W  ROM response: 0 = end of chain; all-ones = invalid.
- uop_valid  out  1  micro-op address presented.
- uop_ready  in  1  downstream ARM emitter accepts the micro-op.
- uop_addr  out  ADDR_W  current micro-op address.
- uop_last  out  1  current micro-op is the final one of the bytecode.
- busy  out  1  state is not IDLE.
- err  out  1  sticky error flag.
- err_code  out  2  01 = invalid address, 10 = step overflow, 00 = none.
- err_clr  in  1  clears an error and returns the block to IDLE.
- insn_count  out  16  count of completed bytecodes; wraps modulo 2^16.

Function
REQ-010 The block SHALL implement the states IDLE, EMIT and ERROR, held in a single registered state variable.
REQ-011 In IDLE: op_ready=1, uop_valid=0. When op_valid=1, the block SHALL load cur = {1'b0, op_code} and step = 0, then go to EMIT on the next cycle.
REQ-012 In EMIT, the outputs SHALL be:
- uop_valid=1
- uop_addr=cur
- rom_addr=cur
- uop_last = (rom_data==0)
- op_ready=0
REQ-013 In EMIT with uop_ready=0, the block SHALL hold all outputs and state stable; the handshake completes only when uop_valid and uop_ready are both 1.
REQ-014 On a completed handshake in EMIT, the block SHALL take exactly one of the following actions, in priority order:
- rom_data==0: go to IDLE, insn_count+1.
- rom_data all-ones: go to ERROR, err_code=01.
- step==MAX_STEPS-1: go to ERROR, err_code=10.
- otherwise: cur=rom_data, step+1, stay in EMIT.
REQ-015 Latency SHALL be one cycle from opcode acceptance to the first uop_valid, with one micro-op per cycle under continuous uop_ready.
REQ-016 There SHALL be one IDLE bubble cycle between consecutive bytecodes.
REQ-017 rom_addr SHALL equal cur in EMIT and {1'b0, op_code} in IDLE; no other ROM timing is assumed.
REQ-018 A bytecode whose own ROM entry is 0 SHALL produce exactly one micro-op with uop_last=1.
REQ-019 In ERROR: err=1, uop_valid=0, op_ready=0, busy=1. The invalid micro-op SHALL already have been emitted with uop_last=0.
REQ-020 err_clr=1 in ERROR SHALL go to IDLE and set err=0 and err_code=00 on the next cycle; err_clr SHALL be ignored in other states.
REQ-021 The step counter SHALL be wide enough for MAX_STEPS-1 and SHALL never wrap.
REQ-022 insn_count SHALL increment only on the final handshake of a bytecode, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-030 With rst=1, on the next edge the block SHALL set:
- state=IDLE
- cur=0, step=0
- uop_valid=0, op_ready=1, busy=0
- err=0, err_code=00
- insn_count=0
- uop_last=0, uop_addr=0
REQ-031 Reset SHALL take priority over every input, including mid-chain in EMIT and in ERROR; a partially emitted chain is abandoned and not counted.

Verification
REQ-040 Production ROM, op_code=0x59, uop_ready=1 -> uop_addr 89, 256, 257 on consecutive cycles; uop_last only on 257; insn_count=1.
REQ-041 Production ROM, op_code=0x30 -> uop_addr 48, 308, 309, 277, 268 with uop_last on 268; then op_code=0x0B -> 11, 268 (last); insn_count=2.
REQ-042 op_code=0x00 -> single uop_addr 0 with uop_last=1; op_ready returns to 1 the following cycle.
REQ-043 op_code=0x5A with uop_ready toggling 1,0,0,1,1 -> outputs held during the low cycles; sequence 90, 260, 259 with no loss or duplication.
REQ-044 Two error cases, each followed by recovery:
- Stub ROM returns 0x1FF for address 256, op_code=0x59 -> uop 89 then 256 emitted; ERROR with err_code=01.
- Self-loop stub ROM -> exactly MAX_STEPS micro-ops, then err_code=10.
- In both cases err_clr -> IDLE, and err=0 on the next cycle.
REQ-045 rst asserted on the second micro-op of op_code=0x30 -> next cycle uop_valid=0, op_ready=1, insn_count unchanged at 0.
